comma_aligner_10b: RTL and testbench

COMMA_ALIGNER_10B -- requirements
Module: comma_aligner_10b

---
 rtl/comma_aligner_10b.sv | 131 +++++++++++++
 tb/tb_comma_aligner_10b.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner_10b.sv
// Bit-aligner for a 10-bit deserializer: hunts the K28.5 comma,
// locks onto its offset and emits realigned symbols one cycle later.
module comma_aligner_10b #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DVI,
  input  logic [9:0] DI,
  output logic       DVO,
  output logic [9:0] DO,
  output logic       LOCK,
  output logic [3:0] ALIGN
);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [6:0] COMMA_P  = 7'b0011111;
  localparam logic [6:0] COMMA_N  = 7'b1100000;

  state_t     state;
  logic [9:0] prev;
  logic       primed;
  logic [3:0] cnt;
  logic [3:0] mis;
  logic [3:0] cnt_inc;
  logic [3:0] mis_inc;
  logic [3:0] low;
  logic [9:0] hit;
  logic [9:0] cand [10];
  logic       hit_at;
  logic       any_hit;
  logic [19:1] win;

  // DI[0] is never part of a candidate at offsets 0..9
  assign win = {prev, DI[9:1]};

  always_comb begin
    hit = '0;
    for (int p = 0; p < 10; p++) begin
      cand[p] = win[19-p -: 10];
      hit[p]  = (win[19-p -: 7] == COMMA_P)
             || (win[19-p -: 7] == COMMA_N);
    end
  end

  always_comb begin
    low = '0;
    for (int p = 9; p >= 0; p--) begin
      if (hit[p]) low = 4'(p);
    end
  end

  assign any_hit = |hit;
  assign hit_at  = hit[ALIGN];
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign mis_inc = (mis == 4'hF) ? mis : mis + 4'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= HUNT;
      prev   <= '0;
      primed <= 1'b0;
      cnt    <= '0;
      mis    <= '0;
      ALIGN  <= '0;
      LOCK   <= 1'b0;
      DVO    <= 1'b0;
      DO     <= '0;
    end else begin
      DVO <= 1'b0;
      if (DVI) begin
        prev   <= DI;
        primed <= 1'b1;
        if (primed) begin
          unique case (state)
            HUNT: begin
              if (any_hit) begin
                ALIGN <= low;
                cnt   <= 4'd1;
                state <= CHECK;
              end
            end
            CHECK: begin
              if (hit_at) begin
                cnt <= cnt_inc;
                if (cnt_inc == LOCK_N) begin
                  state <= LOCKED;
                  LOCK  <= 1'b1;
                  mis   <= '0;
                  DVO   <= 1'b1;
                  DO    <= cand[ALIGN];
                end
              end else if (any_hit) begin
                ALIGN <= low;
                cnt   <= 4'd1;
              end
            end
            LOCKED: begin
              if (hit_at) begin
                mis <= '0;
              end else if (any_hit) begin
                mis <= mis_inc;
              end
              // ALIGN is kept when lock drops
              if (!hit_at && any_hit && mis_inc == UNLOCK_N) begin
                state <= HUNT;
                LOCK  <= 1'b0;
              end else begin
                DVO <= 1'b1;
                DO  <= cand[ALIGN];
              end
            end
            default: begin
              state <= HUNT;
              LOCK  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Scoreboard bench for comma_aligner_10b: directed streams at
// several bit offsets, slips, mixed commas, gaps and async reset.
module tb_comma_aligner_10b;

  localparam logic [9:0] KA = 10'h0FA;
  localparam logic [9:0] KB = 10'h305;
  localparam logic [9:0] KX = 10'h23E;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       DVI = 1'b0;
  logic [9:0] DI  = '0;
  logic       DVO;
  logic [9:0] DO;
  logic       LOCK;
  logic [3:0] ALIGN;

  comma_aligner_10b #(
    .LOCK_CNT  (3),
    .UNLOCK_CNT(4)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .DVI  (DVI),
    .DI   (DI),
    .DVO  (DVO),
    .DO   (DO),
    .LOCK (LOCK),
    .ALIGN(ALIGN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [9:0] d;
    logic [3:0] a;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // slip from offset 3 to 7: outputs stay at offset 3 until unlock
  logic [9:0] c_do [10] = '{10'h0FF, 10'h2B0, 10'h14F, 10'h2B0,
                           10'h000, 10'h000, 10'h000,
                           10'h305, 10'h0FA, 10'h305};
  bit         c_ex [10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  logic [3:0] c_al [10] = '{3, 3, 3, 3, 0, 0, 0, 7, 7, 7};

  logic [9:0] d_w [17] = '{KA, KA, KA, KA, KX, KX, KX, KA, KX,
                           KX, KX, KA, KX, KX, KX, KX, KX};
  logic [9:0] g_w [7]  = '{KA, KA, KX, KX, KX, KX, KX};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exv);
    end
  endtask

  function automatic logic [9:0] sym(input int n);
    return (n % 2 == 0) ? KA : KB;
  endfunction

  function automatic logic sbit(input int pos);
    logic [9:0] s;
    s = sym(pos / 10);
    return s[9 - (pos % 10)];
  endfunction

  // raw word n of an alternating K28.5 stream whose symbols start p bits in
  function automatic logic [9:0] raw(input int n, input int p);
    logic [9:0] w;
    for (int j = 0; j < 10; j++) w[9-j] = sbit(10 * n + 10 - p + j);
    return w;
  endfunction

  task automatic send(input logic [9:0] w, input bit ex,
                      input logic [9:0] ed, input logic [3:0] ea);
    DVI = 1'b1;
    DI  = w;
    if (ex) q.push_back('{cyc + 1, ed, ea});
    @(posedge CLK);
    #1;
    DVI = 1'b0;
    DI  = 10'h155;
  endtask

  task automatic idle();
    DVI = 1'b0;
    DI  = 10'h155;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (DVO === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dvo_unexpected: got DVO=1 want 0 at cyc %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("dvo_cycle", 32'(cyc), 32'(e.cyc));
        chk("do", 32'(DO), 32'(e.d));
        chk("align", 32'(ALIGN), 32'(e.a));
        chk("lock", 32'(LOCK), 32'd1);
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL dvo_missing: got DVO=0 want 1 at cyc %0d", e.cyc);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_dvo", 32'(DVO), 32'd0);
    chk("rst_do", 32'(DO), 32'd0);
    chk("rst_lock", 32'(LOCK), 32'd0);
    chk("rst_align", 32'(ALIGN), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // aligned stream
    for (int i = 0; i < 8; i++) begin
      send(raw(i, 0), i >= 3, sym(i), 4'd0);
      if (i == 2) chk("a_nolock", 32'(LOCK), 32'd0);
      if (i == 3) chk("a_lock", 32'(LOCK), 32'd1);
    end

    // rotated by 3, then slip to 7
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(raw(i, 3), i >= 3, sym(i), 4'd3);
      if (i == 2) chk("b_nolock", 32'(LOCK), 32'd0);
      if (i == 3) chk("b_align", 32'(ALIGN), 32'd3);
    end
    for (int i = 8; i < 18; i++) begin
      send(raw(i, 7), c_ex[i-8], c_do[i-8], c_al[i-8]);
      if (i == 11) chk("c_still", 32'(LOCK), 32'd1);
      if (i == 12) chk("c_unlock", 32'(LOCK), 32'd0);
      if (i == 12) chk("c_held", 32'(ALIGN), 32'd3);
      if (i == 14) chk("c_nolock", 32'(LOCK), 32'd0);
      if (i == 15) chk("c_relock", 32'(ALIGN), 32'd7);
    end

    // interleaved off-offset commas, then a run that drops lock
    do_reset();
    for (int k = 0; k < 17; k++) begin
      send(d_w[k], k >= 3 && k <= 15, d_w[(k > 0) ? k - 1 : 0], 4'd0);
      if (k == 15) chk("d_keep", 32'(LOCK), 32'd1);
      if (k == 16) chk("d_drop", 32'(LOCK), 32'd0);
    end

    // retarget while checking
    do_reset();
    for (int k = 0; k < 7; k++) begin
      send(g_w[k], k >= 5, 10'h0FA, 4'd2);
      if (k == 3) chk("g_retgt", 32'(ALIGN), 32'd2);
      if (k == 4) chk("g_nolock", 32'(LOCK), 32'd0);
    end

    // gapped DVI at offset 5
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(raw(i, 5), i >= 3, sym(i), 4'd5);
      if (i == 2) chk("e_nolock", 32'(LOCK), 32'd0);
      if (i < 6) idle();
      if (i == 3) chk("e_hold", 32'(LOCK), 32'd1);
    end

    // asynchronous reset mid-cycle while locked
    @(negedge CLK);
    #1;
    chk("f_pre_dvo", 32'(DVO), 32'd1);
    RST = 1'b1;
    #1;
    chk("f_dvo", 32'(DVO), 32'd0);
    chk("f_do", 32'(DO), 32'd0);
    chk("f_lock", 32'(LOCK), 32'd0);
    chk("f_align", 32'(ALIGN), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 7; i < 12; i++) begin
      send(raw(i, 5), i >= 10, sym(i), 4'd5);
      if (i == 9) chk("f_nolock", 32'(LOCK), 32'd0);
      if (i == 10) chk("f_relock", 32'(LOCK), 32'd1);
    end

    repeat (3) idle();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
